// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 3x3 keypad, synchronises and debounces the rows, and emits one cell code per press.
// Define KEY_OCCUPANCY_CHECK_EN to refuse presses on occupied cells or after the game has ended.
//
// state     | meaning
// S_SCAN    | rotating column drive, waiting for any row to go high
// S_DEBOUNCE| column frozen, counting ticks with an unchanged row pattern
// S_HOLD    | decision issued, counting quiet ticks before resuming the scan
module keypad_scanner #(
  parameter int SCAN_DIV     = 25000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_key_row,
  output logic [2:0]  o_key_col,
  input  logic [17:0] i_board,
  input  logic [1:0]  i_result,
  output logic [3:0]  o_key_data,
  output logic        o_key_valid,
  output logic        o_key_reject
);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HOLD     = 2'd2
  } state_t;

  localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);
  localparam logic [8:0]  DEB_N    = 9'(DEBOUNCE_CNT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_row_meta;
  logic [2:0]  r_row_sync;
  logic [19:0] r_div;
  logic [2:0]  r_col;
  logic [2:0]  r_pat;
  logic [3:0]  r_code;
  logic [7:0]  r_cnt;
  logic [3:0]  r_key_data;
  logic        r_valid;

  logic        w_tick;
  logic [1:0]  w_row_idx;
  logic [1:0]  w_col_idx;
  logic [3:0]  w_code_now;
  logic [3:0]  w_dec_code;
  logic [8:0]  w_cnt_inc;
  logic [2:0]  w_col_nxt;
  logic [2:0]  w_pat_nxt;
  logic [3:0]  w_code_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_decide;
  logic        w_accept;

  assign w_tick     = (r_div == DIV_LAST);
  assign w_row_idx  = r_row_sync[0] ? 2'd0 : (r_row_sync[1] ? 2'd1 : 2'd2);
  assign w_col_idx  = r_col[0] ? 2'd0 : (r_col[1] ? 2'd1 : 2'd2);
  assign w_code_now = 4'd3 * {2'b00, w_row_idx} + {2'b00, w_col_idx} + 4'd1;
  assign w_cnt_inc  = {1'b0, r_cnt} + 9'd1;
  // With a single-tick debounce the decision is taken on the entry tick, before r_code is loaded.
  assign w_dec_code = (r_state == S_SCAN) ? w_code_now : r_code;

`ifdef KEY_OCCUPANCY_CHECK_EN
  logic [15:0] w_occ;
  logic        r_reject;

  always_comb begin
    w_occ = '0;
    for (int k = 1; k <= 9; k++) begin
      w_occ[k] = i_board[18 - 2 * k] | i_board[19 - 2 * k];
    end
  end

  assign w_accept = (i_result == 2'b00) && !w_occ[w_dec_code];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reject <= 1'b0;
    end else begin
      r_reject <= w_decide & ~w_accept;
    end
  end

  assign o_key_reject = r_reject;
`else
  logic w_unused_game;

  assign w_unused_game = ^{i_board, i_result};
  assign w_accept      = 1'b1;
  assign o_key_reject  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_pat_nxt   = r_pat;
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_cnt;
    w_decide    = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_SCAN: begin
          if (r_row_sync != 3'b000) begin
            w_pat_nxt  = r_row_sync;
            w_code_nxt = w_code_now;
            if (DEB_N <= 9'd1) begin
              w_cnt_nxt   = 8'd0;
              w_state_nxt = S_HOLD;
              w_decide    = 1'b1;
            end else begin
              w_cnt_nxt   = 8'd1;
              w_state_nxt = S_DEBOUNCE;
            end
          end else begin
            w_col_nxt = {r_col[1:0], r_col[2]};
          end
        end
        S_DEBOUNCE: begin
          if (r_row_sync == r_pat) begin
            if (w_cnt_inc >= DEB_N) begin
              w_cnt_nxt   = 8'd0;
              w_state_nxt = S_HOLD;
              w_decide    = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc[7:0];
            end
          end else begin
            w_cnt_nxt   = 8'd0;
            w_state_nxt = S_SCAN;
          end
        end
        S_HOLD: begin
          if (r_row_sync == 3'b000) begin
            if (w_cnt_inc >= DEB_N) begin
              w_cnt_nxt   = 8'd0;
              w_col_nxt   = {r_col[1:0], r_col[2]};
              w_state_nxt = S_SCAN;
            end else begin
              w_cnt_nxt = w_cnt_inc[7:0];
            end
          end else begin
            w_cnt_nxt = 8'd0;
          end
        end
        default: begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_SCAN;
      r_row_meta <= 3'b000;
      r_row_sync <= 3'b000;
      r_div      <= 20'd0;
      r_col      <= 3'b001;
      r_pat      <= 3'b000;
      r_code     <= 4'd0;
      r_cnt      <= 8'd0;
      r_key_data <= 4'd0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_row_meta <= i_key_row;
      r_row_sync <= r_row_meta;
      r_div      <= w_tick ? 20'd0 : r_div + 20'd1;
      r_col      <= w_col_nxt;
      r_pat      <= w_pat_nxt;
      r_code     <= w_code_nxt;
      r_cnt      <= w_cnt_nxt;
      r_valid    <= w_decide & w_accept;
      if (w_decide && w_accept) begin
        r_key_data <= w_dec_code;
      end
    end
  end

  assign o_key_col   = r_col;
  assign o_key_data  = r_key_data;
  assign o_key_valid = r_valid;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Front end of the tic-tac-toe datapath: scans a 3x3 matrix keypad, synchronises and debounces it, and emits one cell code (1..9) per physical press.
- It is the writer of the key_data bus that the game-state block consumes.
- Reads the current board and result and refuses presses on occupied cells or after the game has ended, so the game-state block only ever sees legal moves.

Parameters:
- SCAN_DIV, 25000, clk cycles per scan tick (1 kHz at 25 MHz); legal range 2..2^20.
- DEBOUNCE_CNT, 20, consecutive stable scan ticks required for a press or release; legal range 1..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- key_row  input  3  keypad row sense, active-high, asynchronous to clk.
- key_col  output  3  column drive, one-hot, active-high.
- board  input  18  cell k (1..9): X at bit 18-2k, O at bit 19-2k.
- result  input  2  00 in progress, 01 X win, 10 O win, 11 draw.
- key_data  output  4  last accepted cell code 1..9; 0 = none since reset.
- key_valid  output  1  one-clk pulse: key_data updated this cycle.
- key_reject  output  1  one-clk pulse: debounced press refused.

Behaviour:
- Reset (async on rst_n low, released synchronously): key_col=001, key_data=0, key_valid=0, key_reject=0, state=SCAN, divider=0, debounce count=0, synchronisers=0. Reset mid-press aborts all pending output.
- key_row passes through a 2-flop synchroniser; all decisions use the synchronised value.
- Tick: one-clk strobe when the divider reaches SCAN_DIV-1. The divider then wraps to 0 and free-runs in every state.
- Code mapping: column c (0..2, bit index of key_col), row r (0..2) gives code = 3r + c + 1. If several rows are high in one column, the lowest r wins.
- Occupied(k) = board[18-2k] | board[19-2k].
- SCAN, on tick:
  - synced row nonzero: capture the row pattern and code, set count=1, go DEBOUNCE. key_col stays frozen.
  - synced row zero: rotate key_col 001->010->100->001.
- DEBOUNCE, on tick:
  - pattern equals the captured pattern: count++. When count reaches DEBOUNCE_CNT, go HOLD and issue the decision.
  - pattern differs (including zero): go SCAN with no output and no column advance.
  - DEBOUNCE_CNT=1 means the decision is taken at the entry tick, going straight to HOLD.
- Decision: registered and visible on the clk following the deciding tick (latency 1 clk).
  - result!=00 or Occupied(code): key_reject=1 for 1 clk, key_data unchanged.
  - otherwise: key_data=code and key_valid=1 for 1 clk.
  - board and result are sampled on the deciding tick only.
- HOLD, on tick:
  - synced row zero: count++. When count reaches DEBOUNCE_CNT, rotate key_col and go SCAN.
  - synced row nonzero: count=0.
  - Keys in other columns are invisible until release. Holding a key never repeats output.
- key_valid and key_reject are never high in the same cycle, and are never high on consecutive clk cycles.
- Count width is 8 bits and saturates at DEBOUNCE_CNT. Divider width is 20 bits.

Optional Feature:
- KEY_OCCUPANCY_CHECK_EN defined: decision as above, with occupancy and result gating.
- Undefined: board and result are ignored, every debounced press produces key_valid with key_data=code, and key_reject is tied 0.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_CNT=3, KEY_OCCUPANCY_CHECK_EN defined.
- Reset, no keys, 12 ticks -> key_col sequence 001,010,100,001,...; key_data=0; no pulses.
- Hold row1 in col2 (cell 6), board=0, result=00, for 10 ticks, then release -> exactly one key_valid pulse with key_data=6, 1 clk after the 3rd stable tick. After 3 zero ticks, key_col advances to 001.
- Press cell 1 with board[16]=1 -> key_reject pulse, key_valid stays 0, key_data keeps its prior value. Repeat with board=0, result=01 -> key_reject.
- Bounce: row toggles every tick for 2 ticks on cell 5 -> no pulse, key_col resumes rotation. Then stable for 3 ticks -> key_valid, key_data=5.
- Rows 0 and 2 both high in col0 -> key_data=1. Cell 9 pressed while cell 1 held -> ignored until cell 1 releases.
- Assert rst_n low during DEBOUNCE of cell 3 -> outputs return to reset values immediately, and no pulse follows release of rst_n unless the press is re-debounced.
